// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants for the multicycle control unit: FSM states, supported
// opcodes and ALU operation encodings, plus a small opcode-support helper.
package multicycle_control_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    function automatic logic opcode_supported(input logic [6:0] op);
        case (op)
            OPC_R, OPC_I, OPC_LOAD, OPC_S, OPC_B,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: opcode_supported = 1'b1;
            default:                               opcode_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decode.sv
// Combinational ALU operation decode from instruction fields.
// Ports:
//   opcode_i, funct3_i, funct7_i : latched instruction fields
//   alu_op_o                     : ALU_* operation code
module alu_decode
    import multicycle_control_unit_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] alu_op_o
);

    always_comb begin
        alu_op_o = ALU_ADD;
        case (opcode_i)
            OPC_R, OPC_I: begin
                case (funct3_i)
                    // Subtract exists only in register form; I-type bit 30 is immediate data.
                    3'b000:  alu_op_o = (opcode_i == OPC_R && funct7_i[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op_o = ALU_SLL;
                    3'b010:  alu_op_o = ALU_SLT;
                    3'b011:  alu_op_o = ALU_SLTU;
                    3'b100:  alu_op_o = ALU_XOR;
                    3'b101:  alu_op_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op_o = ALU_OR;
                    default: alu_op_o = ALU_AND;
                endcase
            end
            OPC_B: begin
                case (funct3_i)
                    3'b000, 3'b001: alu_op_o = ALU_XOR;
                    3'b100, 3'b101: alu_op_o = ALU_SLT;
                    3'b110, 3'b111: alu_op_o = ALU_SLTU;
                    default:        alu_op_o = ALU_ADD;
                endcase
            end
            default: alu_op_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle instruction control unit: IDLE -> EXEC -> (MEM) -> WB | TRAP.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   instr_valid/ready     : instruction handshake (accept only in IDLE)
//   opcode/funct3/funct7  : instruction fields, latched on accept
//   addr_lo               : low address bits for alignment and lane select
//   mem_req/mem_ack       : data-memory request / completion
//   alu_op, mem_write     : ALU operation, store byte-enable lanes
//   reg_write, pc_update  : writeback strobes
//   busy, illegal, timeout: status
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          ALIGN_STORE    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [1:0] addr_lo,
    output logic       mem_req,
    input  logic       mem_ack,
    output logic [3:0] alu_op,
    output logic [3:0] mem_write,
    output logic       reg_write,
    output logic       pc_update,
    output logic       busy,
    output logic       illegal,
    output logic       timeout
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [6:0] opcode_q, opcode_d;
    logic [2:0] funct3_q, funct3_d;
    logic [6:0] funct7_q, funct7_d;
    logic       to_cause_q, to_cause_d;   // 1: trap caused by memory timeout

    logic [3:0] dec_alu_op;
    logic       is_mem_op;
    logic       is_store;
    logic       misaligned;
    logic [3:0] lane_base;
    logic [3:0] store_mask;

    alu_decode u_alu_decode (
        .opcode_i (opcode_q),
        .funct3_i (funct3_q),
        .funct7_i (funct7_q),
        .alu_op_o (dec_alu_op)
    );

    assign is_store  = (opcode_q == OPC_S);
    assign is_mem_op = is_store || (opcode_q == OPC_LOAD);

    // funct3[1:0] carries the access size: 00 byte, 01 half, otherwise word.
    always_comb begin
        misaligned = 1'b0;
        lane_base  = 4'b1111;
        case (funct3_q[1:0])
            2'b00: lane_base = 4'b0001;
            2'b01: begin
                lane_base  = 4'b0011;
                misaligned = addr_lo[0];
            end
            default: begin
                lane_base  = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

    assign store_mask = ALIGN_STORE ? 4'(lane_base << addr_lo) : lane_base;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        to_cause_d  = to_cause_q;
        opcode_d    = opcode_q;
        funct3_d    = funct3_q;
        funct7_d    = funct7_q;
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        alu_op      = '0;
        mem_write   = '0;
        reg_write   = 1'b0;
        pc_update   = 1'b0;
        illegal     = 1'b0;
        timeout     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    opcode_d = opcode;
                    funct3_d = funct3;
                    funct7_d = funct7;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op = dec_alu_op;
                if (!opcode_supported(opcode_q) || (is_mem_op && misaligned)) begin
                    to_cause_d = 1'b0;
                    state_d    = ST_TRAP;
                end else if (is_mem_op) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                alu_op    = dec_alu_op;
                mem_req   = 1'b1;
                mem_write = is_store ? store_mask : 4'b0000;
                // Ack on the final wait cycle still completes normally.
                if (mem_ack) begin
                    state_d = ST_WB;
                end else if (wait_cnt_q >= WAIT_LAST) begin
                    to_cause_d = 1'b1;
                    state_d    = ST_TRAP;
                end else begin
                    wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 8'd1;
                end
            end
            ST_WB: begin
                pc_update = 1'b1;
                reg_write = !(is_store || opcode_q == OPC_B);
                state_d   = ST_IDLE;
            end
            ST_TRAP: begin
                illegal = !to_cause_q;
                timeout = to_cause_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            to_cause_q <= 1'b0;
            opcode_q   <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            to_cause_q <= to_cause_d;
            opcode_q   <= opcode_d;
            funct3_q   <= funct3_d;
            funct7_q   <= funct7_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [1:0] addr_lo;
    logic       mem_req;
    logic       mem_ack;
    logic [3:0] alu_op;
    logic [3:0] mem_write;
    logic       reg_write;
    logic       pc_update;
    logic       busy;
    logic       illegal;
    logic       timeout;

    int passed = 0;
    int total  = 0;

    multicycle_control_unit #(
        .TIMEOUT_CYCLES (4),
        .ALIGN_STORE    (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .addr_lo     (addr_lo),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .alu_op      (alu_op),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .pc_update   (pc_update),
        .busy        (busy),
        .illegal     (illegal),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [1:0] a);
        instr_valid = 1'b1;
        opcode      = op;
        funct3      = f3;
        funct7      = f7;
        addr_lo     = a;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0; addr_lo = '0;
        #1;
        total++; if ({busy, mem_req, reg_write, pc_update, illegal, timeout} !== 6'b0)
            $display("FAIL reset_outs got %b want 000000", {busy, mem_req, reg_write, pc_update, illegal, timeout}); else passed++;
        total++; if ({alu_op, mem_write} !== 8'h00)
            $display("FAIL reset_buses got %h want 00", {alu_op, mem_write}); else passed++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        total++; if (instr_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", instr_ready); else passed++;
    endtask

    task automatic test_add();
        issue(OPC_R, 3'b000, 7'b0000000, 2'b00);
        tick(); // EXEC
        total++; if (alu_op !== ALU_ADD) $display("FAIL add_alu got %0d want %0d", alu_op, ALU_ADD); else passed++;
        total++; if ({busy, instr_ready} !== 2'b10) $display("FAIL add_exec_busy got %b want 10", {busy, instr_ready}); else passed++;
        // An instruction offered while busy must not be taken.
        issue(7'b0001111, 3'b000, 7'b0100000, 2'b00);
        tick(); // WB
        instr_valid = 1'b0;
        total++; if ({reg_write, pc_update, illegal} !== 3'b110)
            $display("FAIL add_wb got %b want 110", {reg_write, pc_update, illegal}); else passed++;
        tick(); // IDLE
        total++; if ({busy, instr_ready, reg_write, pc_update} !== 4'b0100)
            $display("FAIL add_idle got %b want 0100", {busy, instr_ready, reg_write, pc_update}); else passed++;
    endtask

    task automatic test_sh_aligned();
        issue(OPC_S, 3'b001, 7'b0, 2'b10);
        tick(); instr_valid = 1'b0; // EXEC
        total++; if (mem_req !== 1'b0) $display("FAIL sh_exec_req got %b want 0", mem_req); else passed++;
        tick(); // MEM 1
        total++; if (mem_write !== 4'b1100) $display("FAIL sh_lanes got %b want 1100", mem_write); else passed++;
        total++; if (mem_req !== 1'b1) $display("FAIL sh_req1 got %b want 1", mem_req); else passed++;
        tick(); // MEM 2
        total++; if (mem_req !== 1'b1) $display("FAIL sh_req2 got %b want 1", mem_req); else passed++;
        tick(); // MEM 3
        total++; if (mem_req !== 1'b1) $display("FAIL sh_req3 got %b want 1", mem_req); else passed++;
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0; // WB
        total++; if ({mem_req, reg_write, pc_update} !== 3'b001)
            $display("FAIL sh_wb got %b want 001", {mem_req, reg_write, pc_update}); else passed++;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL sh_idle got %b want 0", busy); else passed++;
    endtask

    task automatic test_misaligned();
        issue(OPC_S, 3'b010, 7'b0, 2'b01);
        tick(); instr_valid = 1'b0; // EXEC
        total++; if (mem_req !== 1'b0) $display("FAIL mis_exec_req got %b want 0", mem_req); else passed++;
        tick(); // TRAP
        total++; if ({illegal, timeout, mem_req, reg_write, pc_update} !== 5'b10000)
            $display("FAIL mis_trap got %b want 10000", {illegal, timeout, mem_req, reg_write, pc_update}); else passed++;
        tick(); // IDLE
        total++; if ({illegal, busy} !== 2'b00) $display("FAIL mis_pulse got %b want 00", {illegal, busy}); else passed++;
    endtask

    task automatic test_timeout();
        issue(OPC_LOAD, 3'b010, 7'b0, 2'b00);
        tick(); instr_valid = 1'b0; // EXEC
        for (int i = 1; i <= 4; i++) begin
            tick(); // MEM i
            total++; if ({mem_req, timeout} !== 2'b10)
                $display("FAIL to_mem%0d got %b want 10", i, {mem_req, timeout}); else passed++;
            if (i == 1) begin
                total++; if (mem_write !== 4'b0000) $display("FAIL to_lanes got %b want 0000", mem_write); else passed++;
            end
        end
        tick(); // TRAP
        total++; if ({timeout, illegal, mem_req, reg_write} !== 4'b1000)
            $display("FAIL to_trap got %b want 1000", {timeout, illegal, mem_req, reg_write}); else passed++;
        tick(); // IDLE
        total++; if ({timeout, busy} !== 2'b00) $display("FAIL to_pulse got %b want 00", {timeout, busy}); else passed++;
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        total++; if ({busy, instr_ready, reg_write, pc_update} !== 4'b0100)
            $display("FAIL to_late_ack got %b want 0100", {busy, instr_ready, reg_write, pc_update}); else passed++;
    endtask

    task automatic test_ack_on_last_cycle();
        issue(OPC_LOAD, 3'b000, 7'b0, 2'b11);
        tick(); instr_valid = 1'b0; // EXEC
        tick(); tick(); tick(); tick(); // MEM 4
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        total++; if ({reg_write, pc_update, timeout, illegal} !== 4'b1100)
            $display("FAIL ack_last got %b want 1100", {reg_write, pc_update, timeout, illegal}); else passed++;
        tick();
    endtask

    task automatic test_fence_bne();
        issue(7'b0001111, 3'b000, 7'b0, 2'b00);
        tick(); instr_valid = 1'b0;
        tick(); // TRAP
        total++; if (illegal !== 1'b1) $display("FAIL fence_illegal got %b want 1", illegal); else passed++;
        tick();
        issue(OPC_B, 3'b001, 7'b0, 2'b00);
        tick(); instr_valid = 1'b0; // EXEC
        total++; if (alu_op !== ALU_XOR) $display("FAIL bne_alu got %0d want %0d", alu_op, ALU_XOR); else passed++;
        tick(); // WB
        total++; if ({reg_write, pc_update} !== 2'b01) $display("FAIL bne_wb got %b want 01", {reg_write, pc_update}); else passed++;
        tick();
    endtask

    task automatic test_alu_table();
        logic [6:0] ops  [8] = '{OPC_R, OPC_I, OPC_I, OPC_R, OPC_B, OPC_B, OPC_LUI, OPC_I};
        logic [2:0] f3s  [8] = '{3'b000, 3'b101, 3'b000, 3'b101, 3'b110, 3'b100, 3'b000, 3'b111};
        logic [6:0] f7s  [8] = '{7'h20, 7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00};
        logic [3:0] exps [8] = '{ALU_SUB, ALU_SRA, ALU_ADD, ALU_SRL, ALU_SLTU, ALU_SLT, ALU_ADD, ALU_AND};
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], f3s[i], f7s[i], 2'b00);
            tick(); instr_valid = 1'b0;
            total++; if (alu_op !== exps[i]) $display("FAIL alu_tab%0d got %0d want %0d", i, alu_op, exps[i]); else passed++;
            tick(); tick();
        end
    endtask

    task automatic test_reset_mid_mem();
        issue(OPC_LOAD, 3'b010, 7'b0, 2'b00);
        tick(); instr_valid = 1'b0;
        tick(); // MEM 1
        total++; if (mem_req !== 1'b1) $display("FAIL rst_pre_req got %b want 1", mem_req); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({mem_req, busy} !== 2'b00) $display("FAIL rst_async got %b want 00", {mem_req, busy}); else passed++;
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        total++; if ({busy, instr_ready, reg_write, pc_update} !== 4'b0100)
            $display("FAIL rst_ack_ignored got %b want 0100", {busy, instr_ready, reg_write, pc_update}); else passed++;
        issue(OPC_R, 3'b100, 7'b0, 2'b00);
        tick(); instr_valid = 1'b0;
        total++; if (alu_op !== ALU_XOR) $display("FAIL rst_next_alu got %0d want %0d", alu_op, ALU_XOR); else passed++;
        tick();
        total++; if ({reg_write, pc_update} !== 2'b11) $display("FAIL rst_next_wb got %b want 11", {reg_write, pc_update}); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sh_aligned();
        test_misaligned();
        test_timeout();
        test_ack_on_last_cycle();
        test_fence_bne();
        test_alu_table();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
